// File: rtl/titan_defines.sv
// Shared definitions for the Titan MEM stage: flag bit indices, FSM states,
// byte-lane select constants, MEM/WB payload and the load-data aligner.
package titan_defines;

    localparam int FLAG_RD = 0;
    localparam int FLAG_WR = 1;
    localparam int FLAG_B  = 2;
    localparam int FLAG_H  = 3;
    localparam int FLAG_W  = 4;
    localparam int FLAG_U  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

    localparam logic [3:0] SEL_BYTE0   = 4'b0001;
    localparam logic [3:0] SEL_HALF_LO = 4'b0011;
    localparam logic [3:0] SEL_HALF_HI = 4'b1100;
    localparam logic [3:0] SEL_WORD    = 4'b1111;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic [4:0]  waddr;
        logic        we;
        logic        ld_misaligned;
        logic        st_misaligned;
        logic        ld_fault;
        logic        st_fault;
        logic [31:0] badaddr;
    } memwb_t;

    // Picks the addressed byte/half out of the bus word and extends it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input logic        is_b,
                                                 input logic        is_h,
                                                 input logic        is_u);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        if (is_b) return is_u ? {24'b0, b} : {{24{b[7]}}, b};
        if (is_h) return is_u ? {16'b0, h} : {{16{h[15]}}, h};
        return word;
    endfunction

endpackage

// File: rtl/titan_memwb_register.sv
// MEM/WB pipeline register: flush loads a bubble and beats stall, stall holds.
module titan_memwb_register
    import titan_defines::*;
(
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   stall_i,
    input  logic   flush_i,
    input  memwb_t d_i,
    output memwb_t q_o
);

    memwb_t q_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            q_q <= '0;
        end else if (!stall_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/titan_mem_stage.sv
// Titan MEM stage: Wishbone-style load/store sequencer feeding MEM/WB.
// Optional bus timeout enabled by defining TITAN_MEM_TIMEOUT_EN.
module titan_mem_stage
    import titan_defines::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wb_stall_i,
    input  logic        wb_flush_i,
    input  logic [31:0] mem_pc_i,
    input  logic [31:0] mem_result_i,
    input  logic [31:0] mem_store_data_i,
    input  logic [4:0]  mem_waddr_i,
    input  logic        mem_we_i,
    input  logic [5:0]  mem_mem_flags_i,
    input  logic        mem_mem_ex_sel_i,
    output logic [31:0] dport_address_o,
    output logic [31:0] dport_data_o,
    output logic [3:0]  dport_sel_o,
    output logic        dport_we_o,
    output logic        dport_cyc_o,
    output logic        dport_stb_o,
    input  logic [31:0] dport_data_i,
    input  logic        dport_ack_i,
    input  logic        dport_err_i,
    output logic        mem_stall_req_o,
    output logic [31:0] mem_fwd_dat_o,
    output logic [31:0] wb_pc_o,
    output logic [31:0] wb_result_o,
    output logic [4:0]  wb_waddr_o,
    output logic        wb_we_o,
    output logic        wb_ld_misaligned_o,
    output logic        wb_st_misaligned_o,
    output logic        wb_ld_fault_o,
    output logic        wb_st_fault_o,
    output logic [31:0] wb_badaddr_o
);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, data_q, data_d, ld_data_q, ld_data_d;
    logic [3:0]  sel_q, sel_d;
    logic [2:0]  mode_q, mode_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d, fault_q, fault_d, discard_q, discard_d;

    logic        is_rd, is_wr, is_b, is_h, is_w, is_u;
    logic        op, misaligned, mis_acc, start, in_done, mem_fault, timeout;
    logic [1:0]  off;
    memwb_t      memwb_d, memwb_q;
    logic        memwb_flush;

    assign is_rd      = mem_mem_flags_i[FLAG_RD];
    assign is_wr      = mem_mem_flags_i[FLAG_WR];
    assign is_b       = mem_mem_flags_i[FLAG_B];
    assign is_h       = mem_mem_flags_i[FLAG_H];
    assign is_w       = mem_mem_flags_i[FLAG_W];
    assign is_u       = mem_mem_flags_i[FLAG_U];
    assign off        = mem_result_i[1:0];
    assign op         = is_rd | is_wr;
    assign misaligned = (is_h & off[0]) | (is_w & (off != 2'b00));
    assign mis_acc    = op & misaligned;
    assign start      = (state_q == ST_IDLE) & op & !misaligned;
    assign in_done    = (state_q == ST_DONE);

`ifdef TITAN_MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q;

    assign timeout = (state_q == ST_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || start) begin
            cnt_q <= '0;
        end else if (state_q == ST_REQ) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        sel_d     = sel_q;
        we_d      = we_q;
        mode_d    = mode_q;
        off_d     = off_q;
        ld_data_d = ld_data_q;
        fault_d   = fault_q;
        discard_d = discard_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_REQ;
                    addr_d    = {mem_result_i[31:2], 2'b00};
                    we_d      = is_wr;
                    off_d     = off;
                    mode_d    = {is_u, is_h, is_b};
                    fault_d   = 1'b0;
                    discard_d = wb_flush_i;
                    if (is_b) begin
                        sel_d  = SEL_BYTE0 << off;
                        data_d = {4{mem_store_data_i[7:0]}};
                    end else if (is_h) begin
                        sel_d  = off[1] ? SEL_HALF_HI : SEL_HALF_LO;
                        data_d = {2{mem_store_data_i[15:0]}};
                    end else begin
                        sel_d  = SEL_WORD;
                        data_d = mem_store_data_i;
                    end
                end
            end
            ST_REQ: begin
                // A flush mid-cycle lets the bus finish but drops the result.
                discard_d = discard_q | wb_flush_i;
                if (dport_err_i) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end else if (dport_ack_i) begin
                    ld_data_d = load_extract(dport_data_i, off_q, mode_q[0], mode_q[1], mode_q[2]);
                    state_d   = ST_DONE;
                end else if (timeout) begin
                    fault_d = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!wb_stall_i) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            mode_q    <= '0;
            off_q     <= '0;
            ld_data_q <= '0;
            fault_q   <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            mode_q    <= mode_d;
            off_q     <= off_d;
            ld_data_q <= ld_data_d;
            fault_q   <= fault_d;
            discard_q <= discard_d;
        end
    end

    assign dport_address_o = addr_q;
    assign dport_data_o    = data_q;
    assign dport_sel_o     = sel_q;
    assign dport_we_o      = we_q;
    assign dport_cyc_o     = (state_q == ST_REQ);
    assign dport_stb_o     = (state_q == ST_REQ);
    assign mem_stall_req_o = start | (state_q == ST_REQ);
    assign mem_fwd_dat_o   = mem_result_i;

    assign mem_fault = in_done & fault_q;

    always_comb begin
        memwb_d               = '0;
        memwb_d.pc            = mem_pc_i;
        memwb_d.result        = mem_mem_ex_sel_i ? ld_data_q : mem_result_i;
        memwb_d.waddr         = mem_waddr_i;
        memwb_d.we            = mem_we_i & !mis_acc & !mem_fault;
        memwb_d.ld_misaligned = is_rd & misaligned;
        memwb_d.st_misaligned = is_wr & misaligned;
        memwb_d.ld_fault      = mem_fault & !we_q;
        memwb_d.st_fault      = mem_fault & we_q;
        memwb_d.badaddr       = (mis_acc | mem_fault) ? mem_result_i : 32'h0;
    end

    // While the bus cycle is pending (or its result is discarded) WB sees bubbles.
    assign memwb_flush = wb_flush_i | ((mem_stall_req_o | (in_done & discard_q)) & !wb_stall_i);

    titan_memwb_register u_memwb (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .stall_i (wb_stall_i),
        .flush_i (memwb_flush),
        .d_i     (memwb_d),
        .q_o     (memwb_q)
    );

    assign wb_pc_o            = memwb_q.pc;
    assign wb_result_o        = memwb_q.result;
    assign wb_waddr_o         = memwb_q.waddr;
    assign wb_we_o            = memwb_q.we;
    assign wb_ld_misaligned_o = memwb_q.ld_misaligned;
    assign wb_st_misaligned_o = memwb_q.st_misaligned;
    assign wb_ld_fault_o      = memwb_q.ld_fault;
    assign wb_st_fault_o      = memwb_q.st_fault;
    assign wb_badaddr_o       = memwb_q.badaddr;

endmodule

// File: doc/titan_mem_stage.md
Name: titan_mem_stage

Overview:
MEM stage of the Titan pipeline. It consumes the EX/MEM register outputs (address/result, store data, mem flags, write-back controls) and runs load/store transactions on the data port with a Wishbone-style handshake. It aligns and extends load data, detects misaligned and faulting accesses, stalls the pipeline while a bus cycle is outstanding, and drives the MEM/WB register.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles without ack/err before a forced access fault (only with TITAN_MEM_TIMEOUT_EN)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
wb_stall_i  in  1  hold MEM/WB register
wb_flush_i  in  1  load bubble into MEM/WB
mem_pc_i  in  32  instruction PC
mem_result_i  in  32  ALU result; the byte address for loads and stores
mem_store_data_i  in  32  store data (rs2)
mem_waddr_i  in  5  destination register
mem_we_i  in  1  register write enable
mem_mem_flags_i  in  6  [0] read, [1] write, [2] byte, [3] half, [4] word, [5] unsigned
mem_mem_ex_sel_i  in  1  1 selects load data as the write-back value
dport_address_o  out  32  word address {mem_result_i[31:2],2'b00}
dport_data_o  out  32  lane-replicated store data
dport_sel_o  out  4  byte lane select
dport_we_o  out  1  write cycle
dport_cyc_o  out  1  bus cycle active
dport_stb_o  out  1  strobe
dport_data_i  in  32  read data
dport_ack_i  in  1  transfer complete
dport_err_i  in  1  bus error
mem_stall_req_o  out  1  stall IF/ID/EX and EX/MEM
mem_fwd_dat_o  out  32  forwarding value (mem_result_i)
wb_pc_o  out  32  registered PC
wb_result_o  out  32  registered write-back data
wb_waddr_o  out  5  registered destination
wb_we_o  out  1  registered write enable
wb_ld_misaligned_o  out  1  load address misaligned
wb_st_misaligned_o  out  1  store address misaligned
wb_ld_fault_o  out  1  load access fault
wb_st_fault_o  out  1  store access fault
wb_badaddr_o  out  32  faulting or misaligned byte address

Behaviour:
- Reset: all outputs 0, FSM=IDLE, holding registers 0. Reset during a bus cycle drops cyc/stb on the next edge. No abort handshake.
- op = read|write. misaligned = (half & addr[0]) | (word & addr[1:0]!=0).
- FSM IDLE: if op & !misaligned -> REQ, registering address, sel, we and data. Non-memory instructions and misaligned accesses pass straight through to MEM/WB with no stall.
- REQ: cyc=stb=1, and all bus outputs stay stable. On ack, capture the extracted load data. On err, set the fault flag. Either way -> DONE with cyc/stb=0 on the next edge. If ack and err arrive together, err wins.
- DONE: stall low and MEM/WB captures. Stay in DONE while wb_stall_i=1, otherwise -> IDLE.
- mem_stall_req_o = (IDLE & op & !misaligned) | REQ. It is combinational, and a memory op costs a minimum of 3 cycles.
- Store lanes: byte sel=4'b0001<<addr[1:0], data={4{b}}. Half sel = addr[1] ? 1100 : 0011, data={2{h}}. Word sel=1111.
- Load: select the byte or half by addr, then sign-extend or zero-extend by flag[5]. wb_result = mem_mem_ex_sel_i ? load_data : mem_result_i.
- Misaligned or faulting access: wb_we_o=0, the matching flag=1, wb_badaddr_o=mem_result_i. No bus cycle is issued for a misaligned access.
- MEM/WB: wb_stall_i holds all values, and wb_flush_i has priority over the stall and loads a bubble (all 0). A flush while in REQ completes the bus cycle and the result is discarded.

Optional Feature:
TITAN_MEM_TIMEOUT_EN. When defined, a counter runs in REQ. On reaching TIMEOUT_CYCLES without ack or err, the block sets the fault flag, drops cyc/stb and moves to DONE. The counter clears on entry to REQ. When undefined, REQ waits indefinitely and there is no counter logic.

Decomposition:
- Package titan_defines: flag bit indices (FLAG_RD, FLAG_WR, FLAG_B, FLAG_H, FLAG_W, FLAG_U), FSM state encodings, lane-select constants.
- Sub-module titan_memwb_register: the stall/flush pipeline register.

Test Plan:
- LW at 0x100, ack after 2 waits with dport_data_i=0xDEADBEEF -> stall high for 4 cycles, wb_result_o=0xDEADBEEF, wb_we_o=1.
- LB at 0x103 with data 0x80xxxxxx -> wb_result_o=0xFFFFFF80. LBU at the same address -> 0x00000080.
- SH at 0x202 with rs2=0x1234ABCD -> dport_sel_o=1100, dport_data_o=0xABCDABCD, dport_we_o=1.
- LW at 0x101 -> no cyc, no stall, wb_ld_misaligned_o=1, wb_badaddr_o=0x101, wb_we_o=0.
- SW with dport_err_i on the first cycle -> wb_st_fault_o=1. wb_flush_i asserted during REQ -> the bus cycle completes and MEM/WB holds a bubble.
- With TITAN_MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, a load that never receives ack -> cyc drops after 4 cycles and wb_ld_fault_o=1.
